// File: rtl/usbf_func_seq.sv
// usbf_func_seq: Wishbone master that programs the USB function core after reset and services its interrupts.
// Latency: 2 cycles per zero-wait access; 2+4*NUM_EP init accesses; interrupt to ev_valid_o in 6 cycles.
// Backpressure: wb_stb_o held until ack or timeout; events held on ev_valid_o until ev_ready_i.
module usbf_func_seq #(
  parameter int                   NUM_EP       = 2,
  parameter int                   ADDR_W       = 18,
  parameter logic [NUM_EP*32-1:0] EP_CSR_INIT  = {32'h04050A00, 32'h00030A00},
  parameter logic [NUM_EP*32-1:0] EP_INT_INIT  = {NUM_EP{32'h3F3F0000}},
  parameter logic [NUM_EP*32-1:0] EP_BUF0_INIT = {32'h02002000, 32'h02000000},
  parameter logic [NUM_EP*32-1:0] EP_BUF1_INIT = {32'h02003000, 32'h02001000},
  parameter logic [31:0]          INT_MSK_INIT = 32'h000000FF,
  parameter int                   WB_TIMEOUT   = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [31:0]       wb_data_o,
  input  logic [31:0]       wb_data_i,
  input  logic              wb_ack_i,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              inta_i,
  input  logic              intb_i,
  output logic              ev_valid_o,
  input  logic              ev_ready_i,
  output logic [1:0]        ev_ep_o,
  output logic [31:0]       ev_status_o,
  output logic              ready_o,
  output logic              err_o,
  output logic [7:0]        err_cnt_o
);

  localparam logic [2:0] S_INIT_WR = 3'd0;
  localparam logic [2:0] S_WB_WAIT = 3'd1;
  localparam logic [2:0] S_IDLE    = 3'd2;
  localparam logic [2:0] S_RD_SRC  = 3'd3;
  localparam logic [2:0] S_DECODE  = 3'd4;
  localparam logic [2:0] S_RD_EP   = 3'd5;
  localparam logic [2:0] S_EV_HOLD = 3'd6;

  localparam logic [1:0] OP_INIT = 2'd0;
  localparam logic [1:0] OP_SRC  = 2'd1;
  localparam logic [1:0] OP_EP   = 2'd2;

  localparam logic [4:0]  LAST_IDX = 5'(2 + 4*NUM_EP - 1);
  localparam logic [15:0] TO_LAST  = 16'(WB_TIMEOUT - 1);

  // Parameter vectors widened to four endpoints so the slice index never leaves the vector.
  localparam logic [127:0] CSR_V  = 128'(EP_CSR_INIT);
  localparam logic [127:0] INT_V  = 128'(EP_INT_INIT);
  localparam logic [127:0] BUF0_V = 128'(EP_BUF0_INIT);
  localparam logic [127:0] BUF1_V = 128'(EP_BUF1_INIT);

  logic [2:0]        state_q;
  logic [1:0]        op_q;
  logic [4:0]        idx_q;
  logic [1:0]        ep_q;
  logic              src_reinit_q;
  logic [NUM_EP-1:0] src_ep_q;
  logic [15:0]       to_cnt_q;

  logic [3:0]  ep_step;
  logic [7:0]  init_addr;
  logic [31:0] init_data;
  logic        ep_hit;
  logic [1:0]  ep_sel;

  // Address/data of init step idx_q: FA first, then four registers per endpoint, INT_MSK last.
  always_comb begin
    ep_step   = 4'(idx_q - 5'd1);
    init_addr = {2'b01, ep_step, 2'b00};
    init_data = '0;
    if (idx_q == 5'd0) begin
      init_addr = 8'h04;
    end else if (idx_q == LAST_IDX) begin
      init_addr = 8'h08;
      init_data = INT_MSK_INIT;
    end else begin
      case (ep_step[1:0])
        2'd0:    init_data = CSR_V[{ep_step[3:2], 5'd0} +: 32];
        2'd1:    init_data = INT_V[{ep_step[3:2], 5'd0} +: 32];
        2'd2:    init_data = BUF0_V[{ep_step[3:2], 5'd0} +: 32];
        default: init_data = BUF1_V[{ep_step[3:2], 5'd0} +: 32];
      endcase
    end
  end

  // Lowest-numbered endpoint with a pending interrupt bit.
  always_comb begin
    ep_hit = 1'b0;
    ep_sel = 2'd0;
    for (int n = 0; n < NUM_EP; n++) begin
      if (src_ep_q[n] && !ep_hit) begin
        ep_hit = 1'b1;
        ep_sel = 2'(n);
      end
    end
  end

  // Sequencer: issues one Wishbone access at a time and walks init / interrupt service.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_INIT_WR;
      op_q         <= OP_INIT;
      idx_q        <= '0;
      ep_q         <= '0;
      src_reinit_q <= 1'b0;
      src_ep_q     <= '0;
      to_cnt_q     <= '0;
      wb_addr_o    <= '0;
      wb_data_o    <= '0;
      wb_we_o      <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_cyc_o     <= 1'b0;
      ev_valid_o   <= 1'b0;
      ev_ep_o      <= '0;
      ev_status_o  <= '0;
      ready_o      <= 1'b0;
      err_o        <= 1'b0;
      err_cnt_o    <= '0;
    end else begin
      case (state_q)
        S_INIT_WR: begin
          wb_addr_o <= ADDR_W'(init_addr);
          wb_data_o <= init_data;
          wb_we_o   <= 1'b1;
          wb_stb_o  <= 1'b1;
          wb_cyc_o  <= 1'b1;
          op_q      <= OP_INIT;
          to_cnt_q  <= '0;
          state_q   <= S_WB_WAIT;
        end
        S_WB_WAIT: begin
          if (wb_ack_i) begin
            wb_we_o  <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            case (op_q)
              OP_INIT: begin
                if (idx_q == LAST_IDX) begin
                  ready_o <= 1'b1;
                  state_q <= S_IDLE;
                end else begin
                  idx_q   <= idx_q + 5'd1;
                  state_q <= S_INIT_WR;
                end
              end
              OP_SRC: begin
                src_reinit_q <= wb_data_i[28] | wb_data_i[25];
                src_ep_q     <= wb_data_i[NUM_EP-1:0];
                state_q      <= S_DECODE;
              end
              default: begin
                ev_valid_o  <= 1'b1;
                ev_ep_o     <= ep_q;
                ev_status_o <= wb_data_i;
                state_q     <= S_EV_HOLD;
              end
            endcase
          end else if (to_cnt_q == TO_LAST) begin
            // Slave is unresponsive: abandon the access and bring the core up again.
            wb_we_o  <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            err_o    <= 1'b1;
            if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
            ready_o  <= 1'b0;
            idx_q    <= '0;
            state_q  <= S_INIT_WR;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
        end
        S_IDLE: begin
          if (inta_i || intb_i) state_q <= S_RD_SRC;
        end
        S_RD_SRC: begin
          wb_addr_o <= ADDR_W'(8'h0C);
          wb_data_o <= '0;
          wb_we_o   <= 1'b0;
          wb_stb_o  <= 1'b1;
          wb_cyc_o  <= 1'b1;
          op_q      <= OP_SRC;
          to_cnt_q  <= '0;
          state_q   <= S_WB_WAIT;
        end
        S_DECODE: begin
          // Bus reset / attach outrank endpoint bits, which are dropped with the re-init.
          if (src_reinit_q) begin
            ready_o <= 1'b0;
            idx_q   <= '0;
            state_q <= S_INIT_WR;
          end else if (ep_hit) begin
            ep_q    <= ep_sel;
            state_q <= S_RD_EP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RD_EP: begin
          wb_addr_o <= ADDR_W'({2'b01, ep_q, 4'h4});
          wb_data_o <= '0;
          wb_we_o   <= 1'b0;
          wb_stb_o  <= 1'b1;
          wb_cyc_o  <= 1'b1;
          op_q      <= OP_EP;
          to_cnt_q  <= '0;
          state_q   <= S_WB_WAIT;
        end
        S_EV_HOLD: begin
          if (ev_ready_i) begin
            ev_valid_o <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_INIT_WR;
      endcase
    end
  end

endmodule

// File: tb/tb_usbf_func_seq.sv
module tb_usbf_func_seq;
  logic clk = 1'b0;
  logic rst, rst4;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // NUM_EP=2 instance with a zero-wait slave
  logic [17:0] addr2;
  logic [31:0] wdat2, rdat2;
  logic        ack2, we2, stb2, cyc2;
  logic        inta, intb, ev_rdy;
  logic        ev_vld;
  logic [1:0]  ev_ep;
  logic [31:0] ev_st;
  logic        ready2, err2;
  logic [7:0]  errcnt2;
  logic        block_en;
  logic [31:0] src_val, ep0_val, ep1_val;

  usbf_func_seq #(.NUM_EP(2), .WB_TIMEOUT(8)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .wb_addr_o(addr2), .wb_data_o(wdat2), .wb_data_i(rdat2), .wb_ack_i(ack2),
    .wb_we_o(we2), .wb_stb_o(stb2), .wb_cyc_o(cyc2),
    .inta_i(inta), .intb_i(intb),
    .ev_valid_o(ev_vld), .ev_ready_i(ev_rdy), .ev_ep_o(ev_ep), .ev_status_o(ev_st),
    .ready_o(ready2), .err_o(err2), .err_cnt_o(errcnt2)
  );

  assign ack2 = stb2 && !(block_en && we2 && addr2 == 18'h44);

  always_comb begin
    rdat2 = 32'h0;
    if (addr2 == 18'h0C)      rdat2 = src_val;
    else if (addr2 == 18'h44) rdat2 = ep0_val;
    else if (addr2 == 18'h54) rdat2 = ep1_val;
  end

  typedef struct packed { logic we; logic [17:0] addr; logic [31:0] data; } acc_t;
  acc_t log2[$];
  always @(negedge clk) if (stb2 && ack2) log2.push_back('{we2, addr2, wdat2});

  // NUM_EP=4 instance with a 3-wait-state slave
  logic [17:0] addr4;
  logic [31:0] wdat4;
  logic        ack4, we4, stb4, cyc4;
  logic        ev_vld4, ready4, err4;
  logic [1:0]  ev_ep4;
  logic [31:0] ev_st4;
  logic [7:0]  errcnt4;
  logic [1:0]  wc4 = 2'd0;
  int          hc4 = 0;
  logic [17:0] q4a[$];
  int          q4h[$];
  logic [31:0] zero32 = 32'h0;
  logic        zero1 = 1'b0;

  usbf_func_seq #(
    .NUM_EP(4),
    .EP_CSR_INIT({4{32'h00030A00}}), .EP_INT_INIT({4{32'h3F3F0000}}),
    .EP_BUF0_INIT({4{32'h02000000}}), .EP_BUF1_INIT({4{32'h02001000}})
  ) dut4 (
    .clk_i(clk), .rst_i(rst4),
    .wb_addr_o(addr4), .wb_data_o(wdat4), .wb_data_i(zero32), .wb_ack_i(ack4),
    .wb_we_o(we4), .wb_stb_o(stb4), .wb_cyc_o(cyc4),
    .inta_i(zero1), .intb_i(zero1),
    .ev_valid_o(ev_vld4), .ev_ready_i(zero1), .ev_ep_o(ev_ep4), .ev_status_o(ev_st4),
    .ready_o(ready4), .err_o(err4), .err_cnt_o(errcnt4)
  );

  assign ack4 = stb4 && (wc4 == 2'd3);
  always @(posedge clk) wc4 <= (!stb4 || ack4) ? 2'd0 : wc4 + 2'd1;
  always @(negedge clk) begin
    if (stb4 && we4) begin
      if (ack4) begin
        q4a.push_back(addr4);
        q4h.push_back(hc4 + 1);
        hc4 <= 0;
      end else begin
        hc4 <= hc4 + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] src; logic [31:0] ep0; logic [31:0] ep1;
    logic ev; logic [1:0] ep; logic [31:0] st; logic reinit;
  } vec_t;
  vec_t vecs [7];

  logic [17:0] exp_a [10];
  logic [31:0] exp_d [10];

  initial begin
    int base, rdy_edge, lat, hold_bad, wr, rd, hi, k;
    logic ev_seen, rlow;
    logic [1:0] s_ep;
    logic [31:0] s_st;

    exp_a = '{18'h04, 18'h40, 18'h44, 18'h48, 18'h4C, 18'h50, 18'h54, 18'h58, 18'h5C, 18'h08};
    exp_d = '{32'h0, 32'h00030A00, 32'h3F3F0000, 32'h02000000, 32'h02001000,
              32'h04050A00, 32'h3F3F0000, 32'h02002000, 32'h02003000, 32'h000000FF};
    //           src           ep0           ep1          ev  ep    status        reinit
    vecs[0] = '{32'h00000003, 32'h00000011, 32'h00000099, 1'b1, 2'd0, 32'h00000011, 1'b0};
    vecs[1] = '{32'h00000002, 32'h00000011, 32'h00000022, 1'b1, 2'd1, 32'h00000022, 1'b0};
    vecs[2] = '{32'h0000000C, 32'h00000011, 32'h00000022, 1'b0, 2'd0, 32'h00000000, 1'b0};
    vecs[3] = '{32'h10000001, 32'h00000011, 32'h00000022, 1'b0, 2'd0, 32'h00000000, 1'b1};
    vecs[4] = '{32'h02000002, 32'h00000011, 32'h00000022, 1'b0, 2'd0, 32'h00000000, 1'b1};
    vecs[5] = '{32'h00000001, 32'hABCD1234, 32'h00000022, 1'b1, 2'd0, 32'hABCD1234, 1'b0};
    vecs[6] = '{32'h00000000, 32'h00000011, 32'h00000022, 1'b0, 2'd0, 32'h00000000, 1'b0};

    rst = 1'b1; rst4 = 1'b1; inta = 1'b0; intb = 1'b0; ev_rdy = 1'b0; block_en = 1'b0;
    src_val = 32'h0; ep0_val = 32'h0; ep1_val = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_stb", 32'(stb2), 32'd0);
    check("rst_cyc", 32'(cyc2), 32'd0);
    check("rst_we", 32'(we2), 32'd0);
    check("rst_addr", 32'(addr2), 32'd0);
    check("rst_data", wdat2, 32'd0);
    check("rst_ready", 32'(ready2), 32'd0);
    check("rst_ev", {ev_vld, ev_ep, ev_st[28:0]}, 32'd0);
    check("rst_err", {err2, errcnt2}, 32'd0);

    // Init sequence timing and contents
    base = log2.size();
    rst = 1'b0; rst4 = 1'b0;
    rdy_edge = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (ready2 && rdy_edge == 0) rdy_edge = e;
    end
    check("init_ready_edge", 32'(rdy_edge), 32'd20);
    check("init_count", 32'(log2.size() - base), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (base + i < log2.size()) begin
        check($sformatf("init%0d_we", i), 32'(log2[base+i].we), 32'd1);
        check($sformatf("init%0d_addr", i), 32'(log2[base+i].addr), 32'(exp_a[i]));
        check($sformatf("init%0d_data", i), log2[base+i].data, exp_d[i]);
      end
    end

    // Interrupt service vectors
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      src_val = vecs[v].src; ep0_val = vecs[v].ep0; ep1_val = vecs[v].ep1;
      base = log2.size();
      if (v % 2 == 1) intb = 1'b1; else inta = 1'b1;
      ev_seen = 1'b0; rlow = 1'b0; lat = 0; hold_bad = 0; s_ep = 2'd0; s_st = 32'h0;
      for (int e = 1; e <= 40; e++) begin
        @(posedge clk); #1;
        if (e == 1) begin inta = 1'b0; intb = 1'b0; end
        if (!ready2) rlow = 1'b1;
        if (ev_seen && (!ev_vld || ev_ep != s_ep || ev_st != s_st)) hold_bad++;
        if (ev_vld && !ev_seen) begin
          ev_seen = 1'b1; lat = e; s_ep = ev_ep; s_st = ev_st;
        end
      end
      wr = 0; rd = 0;
      for (int i = base; i < log2.size(); i++) if (log2[i].we) wr++; else rd++;
      check($sformatf("vec%0d_event", v), 32'(ev_seen), 32'(vecs[v].ev));
      check($sformatf("vec%0d_reinit", v), 32'(rlow), 32'(vecs[v].reinit));
      check($sformatf("vec%0d_ready_end", v), 32'(ready2), 32'd1);
      check($sformatf("vec%0d_writes", v), 32'(wr), vecs[v].reinit ? 32'd10 : 32'd0);
      check($sformatf("vec%0d_reads", v), 32'(rd), vecs[v].ev ? 32'd2 : 32'd1);
      if (vecs[v].ev) begin
        check($sformatf("vec%0d_latency", v), 32'(lat), 32'd6);
        check($sformatf("vec%0d_ep", v), 32'(s_ep), 32'(vecs[v].ep));
        check($sformatf("vec%0d_status", v), s_st, vecs[v].st);
        check($sformatf("vec%0d_hold", v), 32'(hold_bad), 32'd0);
        @(negedge clk); ev_rdy = 1'b1;
        @(posedge clk); #1;
        check($sformatf("vec%0d_ev_drop", v), 32'(ev_vld), 32'd0);
        @(negedge clk); ev_rdy = 1'b0;
      end
    end

    // Unacknowledged third init write: timeout after 8 stb-high cycles
    @(negedge clk); rst = 1'b1; block_en = 1'b1;
    @(negedge clk); rst = 1'b0;
    k = 0;
    while (!(stb2 && addr2 == 18'h44) && k < 30) begin @(negedge clk); k++; end
    check("to_reached_0x44", 32'(k < 30), 32'd1);
    hi = 0;
    while (stb2 && hi < 50) begin hi++; @(negedge clk); end
    check("to_stb_cycles", 32'(hi), 32'd8);
    check("to_cyc_low", 32'(cyc2), 32'd0);
    check("to_err", 32'(err2), 32'd1);
    check("to_err_cnt", 32'(errcnt2), 32'd1);
    check("to_ready", 32'(ready2), 32'd0);
    block_en = 1'b0;
    k = 0;
    while (!stb2 && k < 10) begin @(negedge clk); k++; end
    check("to_restart_addr", 32'(addr2), 32'h04);
    check("to_restart_we", 32'(we2), 32'd1);
    k = 0;
    while (!ready2 && k < 60) begin @(negedge clk); k++; end
    check("to_ready_again", 32'(ready2), 32'd1);

    // Reset asserted in the middle of a write
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    k = 0;
    while (!(stb2 && addr2 == 18'h48) && k < 30) begin @(negedge clk); k++; end
    rst = 1'b1; #1;
    check("mid_rst_stb", 32'(stb2), 32'd0);
    check("mid_rst_cyc", 32'(cyc2), 32'd0);
    @(negedge clk); rst = 1'b0;
    check("mid_rst_err", 32'(err2), 32'd0);
    check("mid_rst_errcnt", 32'(errcnt2), 32'd0);
    check("mid_rst_ready", 32'(ready2), 32'd0);
    k = 0;
    while (!stb2 && k < 10) begin @(negedge clk); k++; end
    check("mid_rst_restart", 32'(addr2), 32'h04);

    // NUM_EP=4 init against the 3-wait-state slave
    k = 0;
    while (!ready4 && k < 300) begin @(negedge clk); k++; end
    check("ep4_ready", 32'(ready4), 32'd1);
    check("ep4_count", 32'(q4a.size()), 32'd18);
    for (int i = 0; i < 18; i++) begin
      if (i < q4a.size()) begin
        check($sformatf("ep4_addr%0d", i), 32'(q4a[i]),
              (i == 0) ? 32'h04 : (i == 17) ? 32'h08 : 32'(32'h40 + 4 * (i - 1)));
        check($sformatf("ep4_hi%0d", i), 32'(q4h[i]), 32'd4);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/usbf_func_seq.md
# usbf_func_seq

Parametrised Wishbone-master sequencer for the USB function core. After reset it configures the core's function-address and interrupt-mask registers and an arbitrary number of endpoints from parameter vectors. While idle it services `inta_i`/`intb_i` by reading the interrupt source register. Endpoint interrupt status is forwarded to downstream logic over a valid/ready event port; bus-reset and attach events trigger re-initialisation. A per-access Wishbone timeout and error reporting are included. The block sits between the top-level glue and the USB core's Wishbone slave port.

## Interface
- `NUM_EP`, 2: number of endpoints configured and serviced (1..4).
- `ADDR_W`, 18: Wishbone address width. MSB=0 selects the register file.
- `EP_CSR_INIT`, {32'h04050A00, 32'h00030A00}: packed NUM_EP×32 CSR values; EP0 occupies bits [31:0].
- `EP_INT_INIT`, {NUM_EP{32'h3F3F0000}}: packed endpoint interrupt-enable values.
- `EP_BUF0_INIT`, {32'h02002000, 32'h02000000}: packed BUF0 values.
- `EP_BUF1_INIT`, {32'h02003000, 32'h02001000}: packed BUF1 values.
- `INT_MSK_INIT`, 32'h000000FF: value written to INT_MSK (0x08).
- `WB_TIMEOUT`, 255: maximum number of cycles `wb_stb_o` may stay high without an ack (1..65535).
- `clk_i`  in  1  the single clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `wb_addr_o`  out  ADDR_W  byte address.
- `wb_data_o`  out  32  write data.
- `wb_data_i`  in  32  read data.
- `wb_ack_i`  in  1  slave acknowledge.
- `wb_we_o`, `wb_stb_o`, `wb_cyc_o`  out  1 each  Wishbone controls. `cyc` always equals `stb`.
- `inta_i`, `intb_i`  in  1 each  level interrupts from the core.
- `ev_valid_o`  out  1  endpoint event available.
- `ev_ready_i`  in  1  consumer accepts the event.
- `ev_ep_o`  out  2  endpoint number of the event.
- `ev_status_o`  out  32  endpoint INT register contents.
- `ready_o`  out  1  initialisation complete; block is in service mode.
- `err_o`  out  1  sticky; set on any Wishbone timeout.
- `err_cnt_o`  out  8  timeout count, saturating at 255.

## Operation
- Register map:
  - CSR 0x00, FA 0x04, INT_MSK 0x08, INT_SRC 0x0C.
  - Endpoint n: CSR 0x40+0x10n, INT +4, BUF0 +8, BUF1 +0xC.
- Init sequence, all writes, strictly in this order:
  - FA ← 0.
  - For n = 0..NUM_EP-1: CSR, INT, BUF0, BUF1 from parameter slice n.
  - INT_MSK ← INT_MSK_INIT.
  - Total: 2+4·NUM_EP accesses. After the last one, go to IDLE and set `ready_o`=1.
- States: INIT_WR → WB_WAIT → (next INIT_WR | IDLE); IDLE → RD_SRC → WB_WAIT → DECODE; DECODE → (INIT | RD_EP → WB_WAIT → EV_HOLD | IDLE); EV_HOLD → IDLE.
- IDLE: if `inta_i|intb_i`, read INT_SRC and latch the result.
- DECODE, in priority order:
  - Bit 28 (USB reset) or bit 25 (attach): clear `ready_o` and restart the full init sequence. Endpoint bits in the same word are discarded.
  - Else, lowest-numbered n < NUM_EP with bit n set: read endpoint n's INT register.
  - Else: return to IDLE. Bits ≥ NUM_EP are ignored.
- EV_HOLD: drive `ev_valid_o`=1 with `ev_ep_o`=n and `ev_status_o`=read data, held stable until `ev_valid_o&ev_ready_i` at a clock edge. Then go to IDLE, which re-samples the interrupt lines. Remaining endpoints are serviced on later passes.
- Timeout: counter clears at each access issue and increments every cycle `stb` is high.
  - Counter reaches WB_TIMEOUT without ack: drop `stb`/`cyc`/`we`, set `err_o`, increment `err_cnt_o` (saturating), clear `ready_o`, restart init.
- `err_o` and `err_cnt_o` clear only on `rst_i`.

## Timing
- Reset values: all Wishbone outputs 0, `ready_o`=0, `ev_valid_o`=0, `ev_ep_o`=0, `ev_status_o`=0, `err_o`=0, `err_cnt_o`=0. State = first INIT_WR.
- Reset assertion mid-access drops `stb`/`cyc` asynchronously.
- All outputs are registered.
- Issue state: `stb`/`cyc`/`we`/`addr`/`data` become valid at the same edge.
- The ack is sampled at each following edge. At the edge where ack=1:
  - `stb`/`cyc`/`we` fall.
  - Read data is captured.
  - The state advances.
- With a zero-wait slave (ack combinational on stb), each access takes 2 cycles: one `stb`-high cycle, one idle cycle.
- Init with NUM_EP=2 and a zero-wait slave: `ready_o` rises at the 20th edge after `rst_i` deasserts.
- Interrupt latency from IDLE to `ev_valid_o` with a zero-wait slave: 6 cycles.
- Interrupts during init or EV_HOLD are not lost: they are level inputs and are re-sampled in IDLE.

## Test plan
- NUM_EP=2, zero-wait slave, release reset:
  - Exactly 10 writes in this order: 0x04←0, 0x40←00030A00, 0x44←3F3F0000, 0x48←02000000, 0x4C←02001000, 0x50←04050A00, 0x54, 0x58←02002000, 0x5C←02003000, 0x08←000000FF.
  - `ready_o` rises at edge 20.
- INT_SRC returns 0x00000003 and the EP0 INT read returns 0x00000011:
  - Event ep=0, status 0x11.
  - Second interrupt pass produces ep=1.
  - `ev_valid_o` is held for 5 cycles while `ev_ready_i`=0.
- INT_SRC returns 0x10000001: full 10-write re-init, no event, `ready_o` low throughout.
- Slave never acks the third init write, WB_TIMEOUT=8:
  - `stb` drops after 8 high cycles.
  - `err_o`=1, `err_cnt_o`=1.
  - Init restarts from FA.
- NUM_EP=4 with 3-wait-state slave: 18 writes, each `stb`-high for 4 cycles, correct addresses 0x40–0x7C.
- Assert `rst_i` mid-write: `stb`/`cyc` fall in the same cycle; after release, init restarts and counters read 0.
